// File: rtl/myproject_sdiv_37s_5ns_32_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor, one quotient bit
// per cycle, with a saturating signed quotient, an exact signed remainder and a valid/ready handshake.

module myproject_sdiv_37s_5ns_32_seq_chk #(
  parameter int dout_WIDTH = 32,
  parameter int rem_WIDTH  = 6
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  in_ready,
  input logic                  out_valid,
  input logic                  out_ready,
  input logic [dout_WIDTH-1:0] dout,
  input logic [rem_WIDTH-1:0]  rem,
  input logic                  div_by_zero,
  input logic                  overflow
);

  // A result and a free input slot never coexist.
  a_valid_excl_ready: assert property (@(posedge clk) disable iff (rst)
    !(out_valid && in_ready));

  // A stalled result stays put until it is taken.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(dout) && $stable(rem) &&
                                   $stable(div_by_zero) && $stable(overflow)));

endmodule

module myproject_sdiv_37s_5ns_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 37,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CW = $clog2(din0_WIDTH + 1);
  localparam int RW = din1_WIDTH + 1;
  localparam logic [CW-1:0]         CNT_LOAD = CW'(din0_WIDTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [dout_WIDTH-1:0] SAT_MAX  = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SAT_MIN  = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic [din0_WIDTH-1:0]   mag_q, mag_d;
  logic [din1_WIDTH-1:0]   div_q, div_d;
  logic [RW-1:0]           prem_q, prem_d;
  logic [dout_WIDTH-1:0]   dout_q, dout_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic                    out_valid_q, out_valid_d;
  logic                    dbz_q, dbz_d;
  logic                    ovf_q, ovf_d;

  logic [din0_WIDTH-1:0]   din0_mag_s;
  logic [RW-1:0]           trial_s;
  logic                    trial_ge_s;
  logic                    pos_big_s;
  logic                    neg_big_s;

  // Datapath helpers: operand magnitude, restoring trial and saturation detection.
  always_comb begin
    din0_mag_s = din0[din0_WIDTH-1] ? (-din0) : din0;
    // Partial remainder stays below the divisor, so its top bit is always free for the shift.
    trial_s    = {prem_q[RW-2:0], mag_q[din0_WIDTH-1]};
    trial_ge_s = (trial_s >= {1'b0, div_q});
    pos_big_s  = |mag_q[din0_WIDTH-1:dout_WIDTH-1];
    neg_big_s  = (|mag_q[din0_WIDTH-1:dout_WIDTH]) ||
                 (mag_q[dout_WIDTH-1] && (|mag_q[dout_WIDTH-2:0]));
  end

  // Next-state and next-register logic for the divider FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    mag_d       = mag_q;
    div_d       = div_q;
    prem_d      = prem_q;
    dout_d      = dout_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          neg_d  = din0[din0_WIDTH-1];
          mag_d  = din0_mag_s;
          div_d  = din1;
          prem_d = '0;
          if (din1 == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            rem_d       = '0;
            if (din0[din0_WIDTH-1]) begin
              dout_d = SAT_MIN;
            end else if (|din0) begin
              dout_d = SAT_MAX;
            end else begin
              dout_d = '0;
            end
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        if (trial_ge_s) begin
          prem_d = trial_s - {1'b0, div_q};
        end else begin
          prem_d = trial_s;
        end
        // Quotient bits shift in from the bottom as dividend bits leave the top.
        mag_d = {mag_q[din0_WIDTH-2:0], trial_ge_s};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end else begin
          state_d = S_BUSY;
        end
      end

      S_FIX: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        dbz_d       = 1'b0;
        if (neg_q) begin
          rem_d = -prem_q;
          if (neg_big_s) begin
            dout_d = SAT_MIN;
            ovf_d  = 1'b1;
          end else begin
            dout_d = -mag_q[dout_WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end else begin
          rem_d = prem_q;
          if (pos_big_s) begin
            dout_d = SAT_MAX;
            ovf_d  = 1'b1;
          end else begin
            dout_d = mag_q[dout_WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = S_DONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      mag_q       <= '0;
      div_q       <= '0;
      prem_q      <= '0;
      dout_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      mag_q       <= mag_d;
      div_q       <= div_d;
      prem_q      <= prem_d;
      dout_q      <= dout_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  myproject_sdiv_37s_5ns_32_seq_chk #(
    .dout_WIDTH (dout_WIDTH),
    .rem_WIDTH  (RW)
  ) u_chk (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

endmodule

// File: tb/tb_myproject_sdiv_37s_5ns_32_seq.sv
// Bench for the sequential divider: directed vectors with literal expectations plus a
// truncating-division reference model checked on every cycle a result is presented.

`timescale 1ns/1ps

module tb_myproject_sdiv_37s_5ns_32_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [36:0] din0;
  logic [4:0]  din1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dout;
  logic [5:0]  rem;
  logic        out_valid;
  logic        out_ready;
  logic        div_by_zero;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [5:0]  r;
    logic        dz;
    logic        ov;
  } res_t;

  typedef struct packed {
    logic [36:0] a;
    logic [4:0]  b;
    logic [31:0] q;
    logic [5:0]  r;
    logic        dz;
    logic        ov;
    logic [3:0]  hold;
  } vec_t;

  res_t exp_q[$];

  always #5 ap_clk = ~ap_clk;

  myproject_sdiv_37s_5ns_32_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .din0        (din0),
    .din1        (din1),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dout        (dout),
    .rem         (rem),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer division (truncates toward zero), then saturate.
  function automatic res_t model(input logic [36:0] a, input logic [4:0] b);
    res_t   res;
    longint sa, sb, qq, rr;
    sa = longint'($signed(a));
    sb = longint'(b);
    if (sb == 64'sd0) begin
      res.q  = (sa > 64'sd0) ? 32'h7FFF_FFFF : ((sa < 64'sd0) ? 32'h8000_0000 : 32'h0);
      res.r  = 6'd0;
      res.dz = 1'b1;
      res.ov = 1'b0;
    end else begin
      qq     = sa / sb;
      rr     = sa % sb;
      res.r  = rr[5:0];
      res.dz = 1'b0;
      if (qq > 64'sd2147483647) begin
        res.q  = 32'h7FFF_FFFF;
        res.ov = 1'b1;
      end else if (qq < -64'sd2147483648) begin
        res.q  = 32'h8000_0000;
        res.ov = 1'b1;
      end else begin
        res.q  = qq[31:0];
        res.ov = 1'b0;
      end
    end
    return res;
  endfunction

  // Compare process: any presented result must match the oldest outstanding expectation.
  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mon_unexpected_result: got dout=0x%0h with no operation outstanding", dout);
      end else begin
        chk("mon_dout", dout, exp_q[0].q);
        chk("mon_rem", rem, exp_q[0].r);
        chk("mon_div_by_zero", div_by_zero, exp_q[0].dz);
        chk("mon_overflow", overflow, exp_q[0].ov);
        if (out_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the output handshake edge.
  task automatic run_op(input logic [36:0] a, input logic [4:0] b, input logic [31:0] eq,
                        input logic [5:0] er, input logic edz, input logic eov,
                        input bit lit, input int hold);
    int guard;
    int lat;
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", guard);
    end
    exp_q.push_back(model(a, b));
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    din0     = 37'({$urandom(), $urandom()});
    din1     = 5'($urandom());
    lat      = 0;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    // Divide-by-zero results are visible in the cycle right after the accept edge.
    chk("latency", lat, (b == 5'd0) ? 64'd0 : 64'd38);
    if (lit) begin
      chk("lit_dout", dout, eq);
      chk("lit_rem", rem, er);
      chk("lit_div_by_zero", div_by_zero, edz);
      chk("lit_overflow", overflow, eov);
    end
    repeat (hold) begin
      @(posedge ap_clk); #1;
      in_valid = 1'b1;
      din0     = 37'd1000;
      din1     = 5'd3;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 1'b0);
    chk("post_hs_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [36:0] ra;
    logic [4:0]  rb;
    int          seen;

    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = 37'd0;
    din1      = 5'd0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_rem", rem, 6'd0);
    chk("rst_div_by_zero", div_by_zero, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    //                a                 b       q               r      dz    ov    hold
    vecs.push_back({37'd100,           5'd7,  32'd14,         6'd2,  1'b0, 1'b0, 4'd0});
    vecs.push_back({-37'sd100,         5'd7,  32'hFFFF_FFF2,  6'h3E, 1'b0, 1'b0, 4'd10});
    vecs.push_back({-37'sd7,           5'd7,  32'hFFFF_FFFF,  6'd0,  1'b0, 1'b0, 4'd0});
    vecs.push_back({37'h00_8000_0000,  5'd1,  32'h7FFF_FFFF,  6'd0,  1'b0, 1'b1, 4'd0});
    vecs.push_back({37'h10_0000_0000,  5'd1,  32'h8000_0000,  6'd0,  1'b0, 1'b1, 4'd0});
    vecs.push_back({37'h1F_8000_0000,  5'd1,  32'h8000_0000,  6'd0,  1'b0, 1'b0, 4'd0});
    vecs.push_back({37'h00_7FFF_FFFF,  5'd1,  32'h7FFF_FFFF,  6'd0,  1'b0, 1'b0, 4'd0});
    vecs.push_back({37'h1F_0000_0000,  5'd2,  32'h8000_0000,  6'd0,  1'b0, 1'b0, 4'd0});
    vecs.push_back({37'h0F_FFFF_FFFF,  5'd31, 32'h7FFF_FFFF,  6'd1,  1'b0, 1'b1, 4'd0});
    vecs.push_back({37'd5,             5'd0,  32'h7FFF_FFFF,  6'd0,  1'b1, 1'b0, 4'd0});
    vecs.push_back({-37'sd5,           5'd0,  32'h8000_0000,  6'd0,  1'b1, 1'b0, 4'd3});
    vecs.push_back({37'd0,             5'd0,  32'd0,          6'd0,  1'b1, 1'b0, 4'd0});
    vecs.push_back({-37'sd1000,        5'd31, 32'hFFFF_FFE0,  6'h38, 1'b0, 1'b0, 4'd0});
    vecs.push_back({-37'sd3,           5'd7,  32'd0,          6'h3D, 1'b0, 1'b0, 4'd0});

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v.a, v.b, v.q, v.r, v.dz, v.ov, 1'b1, int'(v.hold));
    end

    // Asynchronous reset while a result is being held: outputs clear before any edge.
    din0      = 37'd100;
    din1      = 5'd7;
    in_valid  = 1'b1;
    exp_q.push_back(model(37'd100, 5'd7));
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    seen     = 0;
    while (!out_valid && seen < 100) begin
      @(posedge ap_clk); #1;
      seen++;
    end
    chk("hold_before_rst_dout", dout, 32'd14);
    #2;
    ap_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_dout", dout, 32'd0);
    chk("async_rst_rem", rem, 6'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    // Reset 20 cycles into an operation: nothing may come out afterwards.
    din0     = 37'd1000;
    din1     = 5'd3;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge ap_clk);
    #3;
    ap_rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    @(posedge ap_clk); #1;
    ap_rst    = 1'b0;
    out_ready = 1'b1;
    seen      = 0;
    repeat (50) begin
      @(posedge ap_clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("abort_no_result", seen, 0);
    run_op(37'd1000, 5'd3, 32'd333, 6'd1, 1'b0, 1'b0, 1'b1, 0);

    // Random operands across all dividend magnitudes, checked by the compare process.
    for (int k = 0; k < 200; k++) begin
      ra = 37'({$urandom(), $urandom()}) >> $urandom_range(0, 36);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      rb = 5'($urandom_range(0, 31));
      run_op(ra, rb, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 2)));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
